mxrv_csr_ctrl: RTL and testbench

//  Executes RV32 Zicsr instructions (CSRRW/S/C and the immediate forms) against mxrv_csr_reg,

---
 rtl/mxrv_csr_ctrl.sv | 132 +++++++++++++
 tb/tb_mxrv_csr_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mxrv_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mxrv_csr_ctrl
// Purpose  : RV32 Zicsr executor; read-modify-write sequencer in front of mxrv_csr_reg.
// Revision : 1.0
// ============================================================================
module mxrv_csr_ctrl #(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12,
  parameter bit RO_CHECK   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [31:0]           inst_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic                  flush_i,
  output logic [CSR_ADDR_W-1:0] csr_addr_o,
  output logic                  csr_we_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  output logic                  rd_we_o,
  output logic [4:0]            rd_addr_o,
  output logic [XLEN-1:0]       rd_wdata_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CSR_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_op;
  logic [1:0]            r_kind;
  logic                  r_wreq;
  logic [4:0]            r_rd;
  logic                  r_illegal;
  logic [XLEN-1:0]       r_old;

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [4:0]            w_rs1_idx;
  logic [CSR_ADDR_W-1:0] w_addr;
  logic                  w_wreq;
  logic                  w_illegal;
  logic                  w_accept;
  logic [XLEN-1:0]       w_op;
  logic [XLEN-1:0]       w_wdata;
  logic                  w_resp;

  assign w_opcode  = inst_i[6:0];
  assign w_funct3  = inst_i[14:12];
  assign w_rs1_idx = inst_i[19:15];
  assign w_addr    = inst_i[20 +: CSR_ADDR_W];

  // Set/clear forms only write when the rs1 register index (not its value) is non-zero.
  assign w_wreq    = (w_funct3[1:0] == 2'b01) || (w_rs1_idx != 5'd0);
  assign w_illegal = (w_opcode != 7'b1110011) || (w_funct3[1:0] == 2'b00) ||
                     (RO_CHECK && w_wreq && (w_addr[CSR_ADDR_W-1 -: 2] == 2'b11));
  assign w_op      = w_funct3[2] ? {{(XLEN-5){1'b0}}, w_rs1_idx} : rs1_data_i;

  assign ready_o   = (r_state == S_IDLE) && !rst;
  assign w_accept  = valid_i && ready_o;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_illegal ? S_RESP : S_RD;
      S_RD:    w_next = flush_i ? S_IDLE : S_WR;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_op      <= '0;
      r_kind    <= 2'b00;
      r_wreq    <= 1'b0;
      r_rd      <= 5'd0;
      r_illegal <= 1'b0;
      r_old     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rd      <= inst_i[11:7];
        r_illegal <= w_illegal;
        r_old     <= '0;
        // Rejected ops leave the CSR address bus untouched so nothing downstream is probed.
        if (!w_illegal) begin
          r_addr <= w_addr;
          r_op   <= w_op;
          r_kind <= w_funct3[1:0];
          r_wreq <= w_wreq;
        end
      end
      if (r_state == S_WR) r_old <= csr_rdata_i;
    end
  end

  always_comb begin
    w_wdata = r_op;
    case (r_kind)
      2'b10:   w_wdata = csr_rdata_i | r_op;
      2'b11:   w_wdata = csr_rdata_i & ~r_op;
      default: w_wdata = r_op;
    endcase
  end

  // Reset gates every output combinationally, so a reset landing in WR suppresses the write.
  assign w_resp      = !rst && (r_state == S_RESP);
  assign csr_addr_o  = rst ? '0 : r_addr;
  assign csr_we_o    = !rst && (r_state == S_WR) && r_wreq;
  assign csr_wdata_o = (!rst && (r_state == S_WR)) ? w_wdata : '0;
  assign done_o      = w_resp;
  assign illegal_o   = w_resp && r_illegal;
  assign rd_we_o     = w_resp && !r_illegal && (r_rd != 5'd0);
  assign rd_addr_o   = w_resp ? r_rd : 5'd0;
  assign rd_wdata_o  = w_resp ? r_old : '0;

endmodule
`default_nettype wire

// File: tb/tb_mxrv_csr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxrv_csr_ctrl
// Purpose  : Directed self-checking bench for mxrv_csr_ctrl with a CSR file model.
// Revision : 1.0
// ============================================================================
module tb_mxrv_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] inst_i;
  logic [31:0] rs1_data_i;
  logic        flush_i;
  logic [11:0] csr_addr_o;
  logic        csr_we_o;
  logic [31:0] csr_wdata_o;
  logic [31:0] csr_rdata_i;
  logic        rd_we_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        done_o;
  logic        illegal_o;

  logic [31:0] mem [0:4095];
  logic        pl_we;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ill;
    logic        rdwe;
    logic [4:0]  rd;
    logic [31:0] rdata;
    bit          chk_data;
  } exp_t;
  exp_t exp_q[$];

  mxrv_csr_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .inst_i      (inst_i),
    .rs1_data_i  (rs1_data_i),
    .flush_i     (flush_i),
    .csr_addr_o  (csr_addr_o),
    .csr_we_o    (csr_we_o),
    .csr_wdata_o (csr_wdata_o),
    .csr_rdata_i (csr_rdata_i),
    .rd_we_o     (rd_we_o),
    .rd_addr_o   (rd_addr_o),
    .rd_wdata_o  (rd_wdata_o),
    .done_o      (done_o),
    .illegal_o   (illegal_o)
  );

  always #5 clk = ~clk;

  // CSR file with one-cycle registered read
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (csr_we_o) mem[csr_addr_o] <= csr_wdata_o;
    csr_rdata_i <= mem[csr_addr_o];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_we = 1'b0;
  endtask

  function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {csr, rs1, f3, rd, 7'b1110011};
  endfunction

  task automatic do_op(input string tag, input logic [31:0] inst, input logic [31:0] rs1,
                       input int flush_at, input bit hold, input bit exp_wr,
                       input logic [31:0] exp_wd, input int exp_lat, input int ready_at,
                       input exp_t e);
    int w = 0, nwr = 0, wcyc = 0, ndone = 0, dcyc = 0;
    exp_t ee;
    while (!ready_o && w < 20) begin step(); w++; end
    chk({tag, ":ready_before"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; inst_i = inst; rs1_data_i = rs1;
    if (exp_lat > 0) exp_q.push_back(e);
    step();
    if (!hold) begin
      valid_i = 1'b0; inst_i = $urandom; rs1_data_i = $urandom;
    end
    for (int c = 1; c <= 6; c++) begin
      if (c == flush_at) flush_i = 1'b1;
      chk($sformatf("%s:ready_c%0d", tag, c), 32'(ready_o), 32'(c >= ready_at));
      if (ready_o) valid_i = 1'b0;
      if (c == 1 && exp_lat != 1) chk({tag, ":rd_addr"}, 32'(csr_addr_o), 32'(inst[31:20]));
      if (csr_we_o) begin
        nwr++; wcyc = c;
        chk({tag, ":wdata"}, csr_wdata_o, exp_wd);
        chk({tag, ":waddr"}, 32'(csr_addr_o), 32'(inst[31:20]));
      end
      if (done_o) begin
        ndone++; dcyc = c;
        if (exp_q.size() > 0) begin
          ee = exp_q.pop_front();
          chk({tag, ":illegal"}, 32'(illegal_o), 32'(ee.ill));
          chk({tag, ":rd_we"}, 32'(rd_we_o), 32'(ee.rdwe));
          chk({tag, ":rd_addr_o"}, 32'(rd_addr_o), 32'(ee.rd));
          if (ee.chk_data) chk({tag, ":rd_wdata"}, rd_wdata_o, ee.rdata);
        end
      end
      step();
      flush_i = 1'b0;
    end
    chk({tag, ":n_writes"}, 32'(nwr), 32'(exp_wr));
    if (exp_wr) chk({tag, ":write_cycle"}, 32'(wcyc), 32'd2);
    chk({tag, ":n_done"}, 32'(ndone), 32'(exp_lat > 0));
    if (exp_lat > 0) chk({tag, ":done_cycle"}, 32'(dcyc), 32'(exp_lat));
    chk({tag, ":queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] saved;
    rst = 1'b1; valid_i = 1'b1; flush_i = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    inst_i = enc(12'h340, 5'd1, 3'b001, 5'd5); rs1_data_i = 32'h1;
    repeat (3) step();
    chk("rst:ready", 32'(ready_o), 32'd0);
    chk("rst:we", 32'(csr_we_o), 32'd0);
    chk("rst:done", 32'(done_o), 32'd0);
    chk("rst:addr", 32'(csr_addr_o), 32'd0);
    rst = 1'b0; valid_i = 1'b0;
    #1;
    chk("rel:ready", 32'(ready_o), 32'd1);
    chk("rel:addr", 32'(csr_addr_o), 32'd0);
    chk("rel:outs", {rd_wdata_o[29:0], rd_we_o, illegal_o}, 32'd0);
    step();
    chk("rel:no_done", 32'(done_o), 32'd0);

    preload(12'h340, 32'h11);
    preload(12'h300, 32'h1888);
    preload(12'h304, 32'hFF);
    preload(12'hF14, 32'h7);
    preload(12'h305, 32'h42);

    do_op("csrrw", enc(12'h340, 5'd1, 3'b001, 5'd5), 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd5, rdata: 32'h11, chk_data: 1});
    chk("csrrw:mem", mem[12'h340], 32'hDEADBEEF);
    do_op("csrrs_x0", enc(12'h300, 5'd0, 3'b010, 5'd0), 32'hFFFF, 0, 0, 0, 32'h0, 3, 4,
          '{ill: 0, rdwe: 0, rd: 5'd0, rdata: 32'h1888, chk_data: 1});
    do_op("csrrci", enc(12'h304, 5'd5, 3'b111, 5'd3), 32'h12345678, 0, 0, 1, 32'hFA, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd3, rdata: 32'hFF, chk_data: 1});
    do_op("csrrsi", enc(12'h304, 5'h1F, 3'b110, 5'd7), 32'h0, 0, 0, 1, 32'hFF, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd7, rdata: 32'hFA, chk_data: 1});
    do_op("ro_write", enc(12'hF14, 5'd2, 3'b001, 5'd4), 32'h5, 0, 0, 0, 32'h0, 1, 2,
          '{ill: 1, rdwe: 0, rd: 5'd4, rdata: 32'h0, chk_data: 0});
    do_op("f3_100", enc(12'h340, 5'd1, 3'b100, 5'd8), 32'h5, 0, 0, 0, 32'h0, 1, 2,
          '{ill: 1, rdwe: 0, rd: 5'd8, rdata: 32'h0, chk_data: 0});
    do_op("bad_opc", enc(12'h340, 5'd1, 3'b001, 5'd9) ^ 32'h40, 32'h5, 0, 0, 0, 32'h0, 1, 2,
          '{ill: 1, rdwe: 0, rd: 5'd9, rdata: 32'h0, chk_data: 0});
    do_op("ro_read", enc(12'hF14, 5'd0, 3'b010, 5'd9), 32'hFFFFFFFF, 0, 0, 0, 32'h0, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd9, rdata: 32'h7, chk_data: 1});
    do_op("csrrc", enc(12'h340, 5'd8, 3'b011, 5'd6), 32'h0000FFFF, 0, 0, 1, 32'hDEAD0000, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd6, rdata: 32'hDEADBEEF, chk_data: 1});
    do_op("flush_rd", enc(12'h340, 5'd1, 3'b001, 5'd5), 32'h5A5A5A5A, 1, 0, 0, 32'h0, 0, 2,
          '{ill: 0, rdwe: 0, rd: 5'd0, rdata: 32'h0, chk_data: 0});
    chk("flush_rd:mem", mem[12'h340], 32'hDEAD0000);
    do_op("flush_wr", enc(12'h340, 5'h15, 3'b101, 5'd10), 32'h0, 2, 0, 1, 32'h15, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd10, rdata: 32'hDEAD0000, chk_data: 1});
    do_op("hold_valid", enc(12'h304, 5'd0, 3'b110, 5'd11), 32'h0, 0, 1, 0, 32'h0, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd11, rdata: 32'hFF, chk_data: 1});
    do_op("rw_x0", enc(12'h305, 5'd3, 3'b001, 5'd0), 32'h80000000, 0, 0, 1, 32'h80000000, 3, 4,
          '{ill: 0, rdwe: 0, rd: 5'd0, rdata: 32'h42, chk_data: 1});

    // reset asserted while the write cycle is on the bus
    saved = mem[12'h340];
    valid_i = 1'b1; inst_i = enc(12'h340, 5'd1, 3'b001, 5'd5); rs1_data_i = 32'hAAAA5555;
    step();
    valid_i = 1'b0;
    step();
    chk("rst_wr:we_before", 32'(csr_we_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr:we", 32'(csr_we_o), 32'd0);
    chk("rst_wr:addr", 32'(csr_addr_o), 32'd0);
    chk("rst_wr:wdata", csr_wdata_o, 32'd0);
    chk("rst_wr:ready", 32'(ready_o), 32'd0);
    chk("rst_wr:resp", {27'd0, rd_addr_o} | rd_wdata_o | {29'd0, done_o, rd_we_o, illegal_o}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_wr:idle", 32'(ready_o), 32'd1);
    chk("rst_wr:done", 32'(done_o), 32'd0);
    step();
    chk("rst_wr:mem", mem[12'h340], saved);
    do_op("after_rst", enc(12'h340, 5'd0, 3'b010, 5'd12), 32'h0, 0, 0, 0, 32'h0, 3, 4,
          '{ill: 0, rdwe: 1, rd: 5'd12, rdata: saved, chk_data: 1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
